// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register port. Decodes START/STOP from
// filtered SCL/SDA, matches a 7-bit address and maps bus writes/reads onto
// reg_* through an auto-incrementing 8-bit pointer. SDA is open-drain:
// sda_oe=1 pulls the line low. SCL is never driven.
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data
);
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic             scl_sync1_r, scl_sync2_r, scl_f_r, scl_prev_r;
    logic             sda_sync1_r, sda_sync2_r, sda_f_r, sda_prev_r;
    logic [CNT_W-1:0] scl_cnt_r, sda_cnt_r;

    state_t     state_r, state_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] shift_r, shift_s;
    logic [7:0] ptr_r, ptr_s;
    logic       rw_r, rw_s;
    logic       sda_oe_r, sda_oe_s;
    logic       busy_r, busy_s;
    logic       wr_en_r, wr_en_s;
    logic [7:0] wr_data_r, wr_data_s;
    logic       rd_en_r, rd_en_s;

    logic       scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0] byte_s;

    // SCL synchronizer and stability filter: output follows only after FILTER_LEN equal samples
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync1_r <= 1'b1;
            scl_sync2_r <= 1'b1;
            scl_f_r     <= 1'b1;
            scl_cnt_r   <= CNT_ZERO;
        end else begin
            scl_sync1_r <= scl_in;
            scl_sync2_r <= scl_sync1_r;
            if (scl_sync2_r == scl_f_r) begin
                scl_cnt_r <= CNT_ZERO;
            end else if (scl_cnt_r == CNT_MAX) begin
                scl_f_r   <= scl_sync2_r;
                scl_cnt_r <= CNT_ZERO;
            end else begin
                scl_cnt_r <= scl_cnt_r + CNT_ONE;
            end
        end
    end

    // SDA synchronizer and stability filter, identical to the SCL path so edge order is preserved
    always_ff @(posedge clk) begin
        if (reset) begin
            sda_sync1_r <= 1'b1;
            sda_sync2_r <= 1'b1;
            sda_f_r     <= 1'b1;
            sda_cnt_r   <= CNT_ZERO;
        end else begin
            sda_sync1_r <= sda_in;
            sda_sync2_r <= sda_sync1_r;
            if (sda_sync2_r == sda_f_r) begin
                sda_cnt_r <= CNT_ZERO;
            end else if (sda_cnt_r == CNT_MAX) begin
                sda_f_r   <= sda_sync2_r;
                sda_cnt_r <= CNT_ZERO;
            end else begin
                sda_cnt_r <= sda_cnt_r + CNT_ONE;
            end
        end
    end

    assign scl_rise_s = scl_f_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_f_r & scl_prev_r;
    assign start_s    = scl_f_r & scl_prev_r & sda_prev_r & ~sda_f_r;
    assign stop_s     = scl_f_r & scl_prev_r & ~sda_prev_r & sda_f_r;
    assign byte_s     = {shift_r[6:0], sda_f_r};

    // Protocol next-state and datapath decode
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        ptr_s     = ptr_r;
        rw_s      = rw_r;
        sda_oe_s  = sda_oe_r;
        busy_s    = busy_r;
        wr_en_s   = 1'b0;
        wr_data_s = wr_data_r;
        rd_en_s   = 1'b0;

        // A strobe issued last cycle advances the pointer; a read strobe also captures the data
        if (wr_en_r) begin
            ptr_s = ptr_r + 8'd1;
        end else if (rd_en_r) begin
            ptr_s   = ptr_r + 8'd1;
            shift_s = reg_rd_data;
        end else begin
            ptr_s = ptr_r;
        end

        if (stop_s) begin
            state_s   = IDLE;
            busy_s    = 1'b0;
            sda_oe_s  = 1'b0;
            bit_cnt_s = 3'd0;
        end else if (start_s) begin
            state_s   = ADDR;
            busy_s    = 1'b1;
            sda_oe_s  = 1'b0;
            bit_cnt_s = 3'd0;
        end else begin
            case (state_r)
                ADDR, PTR, WDATA: begin
                    if (scl_rise_s) begin
                        shift_s   = byte_s;
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            case (state_r)
                                ADDR: begin
                                    if (shift_r[6:0] == SLAVE_ADDR) begin
                                        state_s = ADDR_ACK;
                                        rw_s    = sda_f_r;
                                    end else begin
                                        state_s = IGNORE;
                                    end
                                end
                                PTR: begin
                                    ptr_s   = byte_s;
                                    state_s = PTR_ACK;
                                end
                                WDATA: begin
                                    wr_en_s   = 1'b1;
                                    wr_data_s = byte_s;
                                    state_s   = WDATA_ACK;
                                end
                                default: state_s = IDLE;
                            endcase
                        end else begin
                            state_s = state_r;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                // First falling edge asserts the ACK, the next one releases it
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (!sda_oe_r) begin
                            sda_oe_s = 1'b1;
                        end else begin
                            sda_oe_s  = 1'b0;
                            bit_cnt_s = 3'd0;
                            state_s   = (state_r == ADDR_ACK) ? PTR : WDATA;
                        end
                    end else if (scl_rise_s && (state_r == ADDR_ACK) && rw_r) begin
                        // Fetch the first read byte during the ACK clock; the ACK holds to the next fall
                        state_s   = RDATA;
                        rd_en_s   = 1'b1;
                        bit_cnt_s = 3'd0;
                    end else begin
                        state_s = state_r;
                    end
                end
                RDATA: begin
                    if (scl_fall_s) begin
                        sda_oe_s = ~shift_r[7];
                    end else if (scl_rise_s) begin
                        shift_s   = {shift_r[6:0], 1'b0};
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        state_s   = (bit_cnt_r == 3'd7) ? RDATA_ACK : RDATA;
                    end else begin
                        state_s = RDATA;
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_s = 1'b0;
                    end else if (scl_rise_s) begin
                        bit_cnt_s = 3'd0;
                        if (!sda_f_r) begin
                            state_s = RDATA;
                            rd_en_s = 1'b1;
                        end else begin
                            state_s  = IGNORE;
                            sda_oe_s = 1'b0;
                        end
                    end else begin
                        state_s = RDATA_ACK;
                    end
                end
                IDLE:    state_s = IDLE;
                IGNORE:  state_s = IGNORE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            ptr_r      <= 8'h00;
            rw_r       <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_data_r  <= 8'h00;
            rd_en_r    <= 1'b0;
        end else begin
            scl_prev_r <= scl_f_r;
            sda_prev_r <= sda_f_r;
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            ptr_r      <= ptr_s;
            rw_r       <= rw_s;
            sda_oe_r   <= sda_oe_s;
            busy_r     <= busy_s;
            wr_en_r    <= wr_en_s;
            wr_data_r  <= wr_data_s;
            rd_en_r    <= rd_en_s;
        end
    end

    assign sda_oe      = sda_oe_r;
    assign busy        = busy_r;
    assign reg_addr    = ptr_r;
    assign reg_wr_en   = wr_en_r;
    assign reg_wr_data = wr_data_r;
    assign reg_rd_en   = rd_en_r;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C controller drives the
// pins, the register file model returns ~addr, and a negedge monitor logs
// strobes and protocol-rule violations.
`timescale 1ns/1ps
module tb_i2c_target_regs;
    localparam int FILTER_LEN = 3;
    localparam int Q          = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       master_scl, master_sda;
    logic       scl_in, sda_in;
    logic       sda_oe, busy, reg_wr_en, reg_rd_en;
    logic [7:0] reg_addr, reg_wr_data, reg_rd_data;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rd_cnt   = 0;
    int         oe_cnt   = 0;
    int         viol_cnt = 0;
    logic       wr_prev  = 1'b0;
    logic       rd_prev  = 1'b0;
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    always #5 clk = ~clk;

    assign scl_in      = master_scl;
    assign sda_in      = master_sda & ~sda_oe;
    assign reg_rd_data = ~reg_addr;

    i2c_target_regs #(.SLAVE_ADDR(7'h50), .FILTER_LEN(FILTER_LEN)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .busy(busy), .reg_addr(reg_addr),
        .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data)
    );

    // Strobe logger and rule monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wr_data);
        end
        if (reg_rd_en === 1'b1) rd_cnt++;
        if (sda_oe === 1'b1) oe_cnt++;
        if (reg_wr_en === 1'b1 && reg_rd_en === 1'b1) viol_cnt++;
        if ((reg_wr_en === 1'b1 || reg_rd_en === 1'b1) && busy !== 1'b1) viol_cnt++;
        if ((reg_wr_en === 1'b1 && wr_prev === 1'b1) || (reg_rd_en === 1'b1 && rd_prev === 1'b1)) viol_cnt++;
        wr_prev = reg_wr_en;
        rd_prev = reg_rd_en;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic rx);
        cyc(Q); master_sda = b;
        cyc(Q); master_scl = 1'b1;
        cyc(Q); rx = sda_in;
        cyc(Q); master_scl = 1'b0;
    endtask

    // Same as send_bit but with a FILTER_LEN-1 cycle SCL spike in the low phase
    task automatic send_bit_glitch(input logic b, output logic rx);
        cyc(Q); master_sda = b;
        cyc(2); master_scl = 1'b1;
        cyc(FILTER_LEN - 1); master_scl = 1'b0;
        cyc(Q - 2 - (FILTER_LEN - 1)); master_scl = 1'b1;
        cyc(Q); rx = sda_in;
        cyc(Q); master_scl = 1'b0;
    endtask

    task automatic start_cond();
        cyc(Q); master_sda = 1'b1;
        cyc(Q); master_scl = 1'b1;
        cyc(2 * Q); master_sda = 1'b0;
        cyc(2 * Q); master_scl = 1'b0;
    endtask

    task automatic stop_cond();
        cyc(Q); master_sda = 1'b0;
        cyc(Q); master_scl = 1'b1;
        cyc(2 * Q); master_sda = 1'b1;
        cyc(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic rx;
        for (int i = 7; i >= 0; i--) send_bit(d[i], rx);
        send_bit(1'b1, rx);
        acked = ~rx;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic rx;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, rx);
            d[i] = rx;
        end
        send_bit(~ack, rx);
    endtask

    task automatic test_reset();
        master_scl = 1'b1; master_sda = 1'b1; reset = 1'b1;
        cyc(3);
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got=%b want=0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b want=0", reg_wr_en); end
        n_checks++; if (reg_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b want=0", reg_rd_en); end
        n_checks++; if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL reset_reg_addr got=%h want=00", reg_addr); end
        n_checks++; if (reg_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got=%h want=00", reg_wr_data); end
        reset = 1'b0;
        cyc(10);
    endtask

    task automatic test_write_burst();
        logic a0, a1, a2, a3;
        int base;
        base = wr_addr_q.size();
        start_cond();
        send_byte(8'hA0, a0); send_byte(8'h10, a1); send_byte(8'h5A, a2); send_byte(8'hC3, a3);
        n_checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL wb_acks got=%b want=1111", {a0, a1, a2, a3}); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wb_busy_mid got=%b want=1", busy); end
        stop_cond();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wb_busy_after got=%b want=0", busy); end
        n_checks++;
        if (wr_addr_q.size() != base + 2) begin
            n_fail++; $display("FAIL wb_wr_count got=%0d want=2", wr_addr_q.size() - base);
        end else begin
            if ({wr_addr_q[base], wr_data_q[base]} !== 16'h105A) begin
                n_fail++; $display("FAIL wb_wr0 got=%h/%h want=10/5a", wr_addr_q[base], wr_data_q[base]);
            end
            n_checks++;
            if ({wr_addr_q[base+1], wr_data_q[base+1]} !== 16'h11C3) begin
                n_fail++; $display("FAIL wb_wr1 got=%h/%h want=11/c3", wr_addr_q[base+1], wr_data_q[base+1]);
            end
        end
    endtask

    task automatic test_read_rs();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        int rd_base, wr_base;
        rd_base = rd_cnt; wr_base = wr_addr_q.size();
        start_cond();
        send_byte(8'hA0, a0); send_byte(8'h20, a1);
        start_cond();
        send_byte(8'hA1, a2);
        recv_byte(1'b1, d0);
        recv_byte(1'b0, d1);
        cyc(2);
        n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rd_acks got=%b want=111", {a0, a1, a2}); end
        n_checks++; if (d0 !== 8'hDF) begin n_fail++; $display("FAIL rd_byte0 got=%h want=df", d0); end
        n_checks++; if (d1 !== 8'hDE) begin n_fail++; $display("FAIL rd_byte1 got=%h want=de", d1); end
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_after_nack got=%b want=0", sda_oe); end
        stop_cond();
        n_checks++; if (rd_cnt - rd_base != 2) begin n_fail++; $display("FAIL rd_count got=%0d want=2", rd_cnt - rd_base); end
        n_checks++; if (wr_addr_q.size() != wr_base) begin n_fail++; $display("FAIL rd_no_writes got=%0d want=0", wr_addr_q.size() - wr_base); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1, a2;
        int rd_base, wr_base, oe_base;
        rd_base = rd_cnt; wr_base = wr_addr_q.size(); oe_base = oe_cnt;
        start_cond();
        send_byte(8'hA2, a0); send_byte(8'h01, a1); send_byte(8'h55, a2);
        n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL mm_acks got=%b want=000", {a0, a1, a2}); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mm_busy_mid got=%b want=1", busy); end
        stop_cond();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mm_busy_after got=%b want=0", busy); end
        n_checks++; if (oe_cnt != oe_base) begin n_fail++; $display("FAIL mm_oe_cycles got=%0d want=0", oe_cnt - oe_base); end
        n_checks++; if ((rd_cnt != rd_base) || (wr_addr_q.size() != wr_base)) begin
            n_fail++; $display("FAIL mm_strobes got=%0d/%0d want=0/0", wr_addr_q.size() - wr_base, rd_cnt - rd_base);
        end
    endtask

    task automatic test_ptr_wrap();
        logic a0, a1, a2, a3, a4, a5, a6;
        logic [7:0] d0, d1;
        int base;
        base = wr_addr_q.size();
        start_cond();
        send_byte(8'hA0, a0); send_byte(8'hFF, a1); send_byte(8'h11, a2); send_byte(8'h22, a3);
        stop_cond();
        n_checks++;
        if (wr_addr_q.size() != base + 2) begin
            n_fail++; $display("FAIL wrap_wr_count got=%0d want=2", wr_addr_q.size() - base);
        end else begin
            if ({wr_addr_q[base], wr_data_q[base]} !== 16'hFF11) begin
                n_fail++; $display("FAIL wrap_wr0 got=%h/%h want=ff/11", wr_addr_q[base], wr_data_q[base]);
            end
            n_checks++;
            if ({wr_addr_q[base+1], wr_data_q[base+1]} !== 16'h0022) begin
                n_fail++; $display("FAIL wrap_wr1 got=%h/%h want=00/22", wr_addr_q[base+1], wr_data_q[base+1]);
            end
        end
        start_cond();
        send_byte(8'hA0, a4); send_byte(8'hFF, a5);
        start_cond();
        send_byte(8'hA1, a6);
        recv_byte(1'b1, d0);
        recv_byte(1'b0, d1);
        stop_cond();
        n_checks++; if ({a0, a1, a2, a3, a4, a5, a6} !== 7'h7F) begin n_fail++; $display("FAIL wrap_acks got=%b want=1111111", {a0, a1, a2, a3, a4, a5, a6}); end
        n_checks++; if (d0 !== 8'h00) begin n_fail++; $display("FAIL wrap_rd0 got=%h want=00", d0); end
        n_checks++; if (d1 !== 8'hFF) begin n_fail++; $display("FAIL wrap_rd1 got=%h want=ff", d1); end
        n_checks++; if (reg_addr !== 8'h01) begin n_fail++; $display("FAIL wrap_ptr_final got=%h want=01", reg_addr); end
    endtask

    task automatic test_abort();
        logic a0, a1, rx;
        int base;
        base = wr_addr_q.size();
        start_cond();
        send_byte(8'hA0, a0); send_byte(8'h30, a1);
        send_bit(1'b1, rx); send_bit(1'b0, rx); send_bit(1'b1, rx); send_bit(1'b1, rx);
        stop_cond();
        n_checks++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL abort_acks got=%b want=11", {a0, a1}); end
        n_checks++; if (wr_addr_q.size() != base) begin n_fail++; $display("FAIL abort_no_write got=%0d want=0", wr_addr_q.size() - base); end
        n_checks++; if ({busy, sda_oe} !== 2'b00) begin n_fail++; $display("FAIL abort_idle got=%b want=00", {busy, sda_oe}); end
    endtask

    task automatic test_glitch();
        logic a0, a1, a2, rx;
        logic [7:0] d;
        int base;
        base = wr_addr_q.size();
        d = 8'h96;
        start_cond();
        send_byte(8'hA0, a0); send_byte(8'h40, a1);
        for (int i = 7; i >= 0; i--) begin
            if (i == 3) send_bit_glitch(d[i], rx);
            else send_bit(d[i], rx);
        end
        send_bit(1'b1, rx);
        a2 = ~rx;
        stop_cond();
        n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL glitch_acks got=%b want=111", {a0, a1, a2}); end
        n_checks++;
        if (wr_addr_q.size() != base + 1) begin
            n_fail++; $display("FAIL glitch_wr_count got=%0d want=1", wr_addr_q.size() - base);
        end else begin
            if ({wr_addr_q[base], wr_data_q[base]} !== 16'h4096) begin
                n_fail++; $display("FAIL glitch_wr got=%h/%h want=40/96", wr_addr_q[base], wr_data_q[base]);
            end
        end
    endtask

    task automatic test_reset_in_ack();
        logic a0, a1, a2, rx;
        logic [7:0] v;
        int base;
        v = 8'hA0;
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(v[i], rx);
        cyc(Q);
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_ack_driving got=%b want=1", sda_oe); end
        reset = 1'b1;
        cyc(1);
        n_checks++; if ({sda_oe, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_ack_outputs got=%b want=00", {sda_oe, busy}); end
        reset = 1'b0; master_sda = 1'b1; master_scl = 1'b1;
        cyc(20);
        base = wr_addr_q.size();
        start_cond();
        send_byte(8'hA0, a0); send_byte(8'h50, a1); send_byte(8'h77, a2);
        stop_cond();
        n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rst_after_acks got=%b want=111", {a0, a1, a2}); end
        n_checks++;
        if (wr_addr_q.size() != base + 1) begin
            n_fail++; $display("FAIL rst_after_wr_count got=%0d want=1", wr_addr_q.size() - base);
        end else begin
            if ({wr_addr_q[base], wr_data_q[base]} !== 16'h5077) begin
                n_fail++; $display("FAIL rst_after_wr got=%h/%h want=50/77", wr_addr_q[base], wr_data_q[base]);
            end
        end
    endtask

    task automatic test_strobe_rules();
        n_checks++; if (viol_cnt != 0) begin n_fail++; $display("FAIL strobe_rules got=%0d want=0", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_rs();
        test_addr_mismatch();
        test_ptr_wrap();
        test_abort();
        test_glitch();
        test_reset_in_ack();
        test_strobe_rules();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) RTL: the responding end of the bus the I2C agent's interface drives and monitors. It decodes START/STOP, matches a 7-bit address, ACKs, and maps bus writes/reads onto a byte-wide register port through an auto-incrementing 8-bit register pointer. SDA is open-drain, so the block only ever pulls the line low. SCL is never driven; there is no clock stretching.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit target address; the R/W bit is excluded.
- FILTER_LEN, 3, number of consecutive equal synchronized samples needed before a filtered SCL/SDA value updates (≥1).
- clk  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL pin level (asynchronous).
- sda_in  in  1  raw SDA pin level (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release (high-Z).
- busy  out  1  high from a detected START until a detected STOP.
- reg_addr  out  8  register pointer; drives both write and read address.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  8  write data; valid while reg_wr_en is high.
- reg_rd_en  out  1  one-cycle read strobe. reg_rd_data is sampled in the same cycle.
- reg_rd_data  in  8  read data, combinational from reg_addr.

## Operation
- Input path:
  - 2-flop synchronizer on each pin, then the FILTER_LEN stability filter.
  - Edge detectors run on the filtered values.
- Bus conditions:
  - START (including repeated START) = filtered SDA falls while filtered SCL is high.
  - STOP = filtered SDA rises while SCL is high.
- Sampling and driving:
  - SDA is sampled on the filtered SCL rising edge.
  - sda_oe changes only in the cycle after a filtered SCL falling edge, except on STOP/reset.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Bit counter: 3-bit, MSB first, cleared on every START.
- START from any state → ADDR; busy=1.
- STOP from any state → IDLE; busy=0; sda_oe=0 on the next cycle.
- ADDR, after 8 bits:
  - addr[7:1]==SLAVE_ADDR → ADDR_ACK, and the R/W bit is latched.
  - Otherwise → IGNORE: no ACK, no strobes, wait for START or STOP.
  - Address 0 (general call) is not recognized.
- ACK phases (ADDR_ACK, PTR_ACK, WDATA_ACK): sda_oe=1 from the falling edge after bit 8 until the falling edge after the 9th clock.
- After ADDR_ACK:
  - W → PTR.
  - R → RDATA. At the first RDATA entry: reg_rd_en pulses, the shift register loads reg_rd_data, and the pointer increments mod 256.
- PTR: 8 bits load the pointer → PTR_ACK → WDATA.
- WDATA:
  - One cycle after the 8th bit's rising edge: reg_wr_en=1 with reg_addr=ptr and reg_wr_data=byte.
  - The pointer increments mod 256 in the cycle after the strobe.
  - Then → WDATA_ACK → WDATA.
- RDATA:
  - sda_oe = ~shift[7] after each falling edge, 8 bits.
  - Then → RDATA_ACK with SDA released.
- RDATA_ACK, sampled on the 9th rising edge:
  - SDA=0 (controller ACK): reg_rd_en pulses one cycle later, the shift register reloads, the pointer increments → RDATA.
  - SDA=1 (NACK) → IGNORE with SDA released.
- Partial bytes are discarded on START or STOP, with no strobe.
- Write-then-read with repeated START sets the pointer and then reads from it.

## Timing
- Reset values:
  - sda_oe=0, busy=0, reg_wr_en=0, reg_rd_en=0, reg_addr=8'h00, reg_wr_data=8'h00.
  - State IDLE, bit counter 0, filter outputs 1.
- Input latency: a pin change reaches the FSM 2+FILTER_LEN cycles later.
- Pulses shorter than FILTER_LEN cycles are rejected.
- Required bus timing: SCL high and low phases ≥ 2·(FILTER_LEN+2) clk cycles; SDA setup/hold around SCL edges ≥ FILTER_LEN+2 cycles.
- sda_oe update: one cycle after the filtered SCL falling edge is detected.
- reg_wr_en and reg_rd_en:
  - Exactly one cycle each.
  - Never both high in the same cycle.
  - Never high outside busy.
- Reset mid-transfer, including during ACK drive: all outputs take their reset values on the next cycle. Any in-progress byte is lost.
- Simultaneous STOP and SCL edge cannot occur, because a STOP requires SCL high. If START and a stale bit count coincide, START wins.

## Test plan
- Write burst: S, 0xA0, ptr 0x10, data 0x5A, 0xC3, P → ACK on all 4 bytes; reg_wr_en at (0x10,0x5A) then (0x11,0xC3); busy falls after P.
- Read with repeated START: S, 0xA0, ptr 0x20, Sr, 0xA1; two reads with model rd_data = ~addr; controller ACK then NACK → SDA carries 0xDF then 0xDE; sda_oe=0 after the NACK; reg_rd_en count = 2.
- Address mismatch: S, 0xA2, 0x01, 0x55, P → sda_oe never 1; no strobes; busy 1→0.
- Pointer wrap: ptr 0xFF, write 0x11, 0x22 → writes at 0xFF then 0x00. Same for reads wrapping past 0xFF.
- Aborts and glitches:
  - STOP after 4 data bits → no reg_wr_en; state IDLE.
  - SCL glitch of FILTER_LEN-1 cycles mid-byte → no extra bit counted; the byte is still written correctly.
- Reset during ADDR_ACK (sda_oe=1) → sda_oe=0 and busy=0 one cycle later; the next valid write transaction succeeds.
